// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue scheduler sharing one pipelined FPU between two requesters.
// A latency-matched tag tracker pairs each FPU result with its owner, and per-requester credits bound outstanding work.
module fpu_issue_arbiter #(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 4,
    parameter int FPU_LATENCY = 6,
    parameter int MAX_OUT     = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                hold,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_operand1,
    input  logic [2*DATA_W-1:0] req_operand2,
    input  logic [3:0]          req_operation,
    input  logic [2*TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0]   fpu_operand1,
    output logic [DATA_W-1:0]   fpu_operand2,
    output logic [1:0]          fpu_operation,
    input  logic [DATA_W-1:0]   fpu_result,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                idle
);

    localparam int DEPTH = FPU_LATENCY + 1;
    localparam int TAIL  = DEPTH - 1;
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    logic [2:0]        cnt [2];
    logic              last_gnt;
    logic [DEPTH-1:0]  trk_v;
    logic              trk_id  [DEPTH];
    logic [TAG_W-1:0]  trk_tag [DEPTH];

    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [1:0]        opc_q;

    logic [1:0]        elig;
    logic [1:0]        rsp_dec;
    logic              grant;
    logic              winner;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;
    logic [1:0]        sel_opc;
    logic [TAG_W-1:0]  sel_tag;

    // A credit returning this cycle is usable immediately, so a full requester
    // can re-issue in the very cycle its oldest result comes back.
    always_comb begin
        rsp_dec = 2'b00;
        elig    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rsp_dec[i] = !RST && trk_v[TAIL] && (trk_id[TAIL] == (i == 1));
            elig[i]    = req_valid[i] && !hold && !RST &&
                         ((cnt[i] < MAX_CNT) || rsp_dec[i]);
        end
        grant     = |elig;
        winner    = (elig == 2'b11) ? ~last_gnt : elig[1];
        req_ready = !grant ? 2'b00 : (winner ? 2'b10 : 2'b01);
        sel_op1   = winner ? req_operand1[DATA_W +: DATA_W] : req_operand1[0 +: DATA_W];
        sel_op2   = winner ? req_operand2[DATA_W +: DATA_W] : req_operand2[0 +: DATA_W];
        sel_opc   = winner ? req_operation[3:2] : req_operation[1:0];
        sel_tag   = winner ? req_tag[TAG_W +: TAG_W] : req_tag[0 +: TAG_W];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_gnt <= 1'b1;
            trk_v    <= '0;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
        end else begin
            if (grant) begin
                last_gnt <= winner;
            end
            trk_v <= {trk_v[DEPTH-2:0], grant};
            for (int i = 0; i < 2; i++) begin
                case ({req_ready[i], rsp_dec[i]})
                    2'b10:   cnt[i] <= cnt[i] + 3'd1;
                    2'b01:   cnt[i] <= cnt[i] - 3'd1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Data path carries no reset; outputs are masked while RST is high.
    always_ff @(posedge CLK) begin
        op1_q      <= grant ? sel_op1 : '0;
        op2_q      <= grant ? sel_op2 : '0;
        opc_q      <= grant ? sel_opc : '0;
        trk_id[0]  <= grant & winner;
        trk_tag[0] <= grant ? sel_tag : '0;
        for (int k = 1; k < DEPTH; k++) begin
            trk_id[k]  <= trk_id[k-1];
            trk_tag[k] <= trk_tag[k-1];
        end
    end

    assign fpu_operand1  = RST ? '0 : op1_q;
    assign fpu_operand2  = RST ? '0 : op2_q;
    assign fpu_operation = RST ? '0 : opc_q;
    assign rsp_valid     = !RST && trk_v[TAIL];
    assign rsp_id        = !RST && trk_id[TAIL];
    assign rsp_tag       = RST ? '0 : trk_tag[TAIL];
    assign rsp_result    = fpu_result;
    assign idle          = RST || ((trk_v == '0) && (cnt[0] == 3'd0) && (cnt[1] == 3'd0));

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter with a behavioural 6-stage FPU and an in-order response scoreboard.
module tb_fpu_issue_arbiter;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int LAT = 6;
    localparam int MO = 4;

    localparam logic [31:0] ONE   = 32'h3F800000;
    localparam logic [31:0] TWO   = 32'h40000000;
    localparam logic [31:0] THREE = 32'h40400000;
    localparam logic [31:0] FOUR  = 32'h40800000;
    localparam logic [31:0] FIVE  = 32'h40A00000;
    localparam logic [31:0] SIX   = 32'h40C00000;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            hold = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_operand1 = '0;
    logic [2*DW-1:0] req_operand2 = '0;
    logic [3:0]      req_operation = '0;
    logic [2*TW-1:0] req_tag = '0;
    logic [DW-1:0]   fpu_operand1;
    logic [DW-1:0]   fpu_operand2;
    logic [1:0]      fpu_operation;
    logic [DW-1:0]   fpu_result;
    logic            rsp_valid;
    logic            rsp_id;
    logic [TW-1:0]   rsp_tag;
    logic [DW-1:0]   rsp_result;
    logic            idle;

    fpu_issue_arbiter #(.DATA_W(DW), .TAG_W(TW), .FPU_LATENCY(LAT), .MAX_OUT(MO)) dut (
        .CLK(CLK), .RST(RST), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_operand1(req_operand1), .req_operand2(req_operand2),
        .req_operation(req_operation), .req_tag(req_tag),
        .fpu_operand1(fpu_operand1), .fpu_operand2(fpu_operand2),
        .fpu_operation(fpu_operation), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .idle(idle)
    );

    always #5 CLK = ~CLK;

    // Behavioural FPU: normal single-precision values only, no reset.
    function automatic real f2d(logic [31:0] x);
        logic [63:0] b;
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = 11'(x[30:23]) + 11'd896;
        b = {x[31], e, x[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] d2f(real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] fpu_calc(logic [31:0] x, logic [31:0] y, logic [1:0] op);
        real a;
        real b;
        a = f2d(x);
        b = f2d(y);
        if (op[1]) return d2f(a * b);
        if (op[0]) return d2f(a - b);
        return d2f(a + b);
    endfunction

    logic [DW-1:0] pipe [LAT];
    always @(posedge CLK) begin
        pipe[0] <= fpu_calc(fpu_operand1, fpu_operand2, fpu_operation);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign fpu_result = pipe[LAT-1];

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    typedef struct {
        logic        id;
        logic [3:0]  tag;
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t q[$];

    // Every cycle: a response must appear exactly when the oldest accept is LAT+1 cycles old.
    always @(negedge CLK) begin : monitor
        logic due;
        due = (q.size() > 0) && (q[0].cyc + LAT + 1 == cyc);
        chk("rsp_valid", 32'(rsp_valid), 32'(due));
        if (due) begin
            if (rsp_valid) begin
                chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
                chk("rsp_result", rsp_result, q[0].res);
            end
            void'(q.pop_front());
        end
    end

    typedef struct {
        logic [1:0]  valid;
        logic        hold;
        logic [31:0] a0, b0;
        logic [1:0]  op0;
        logic [3:0]  tag0;
        logic [31:0] a1, b1;
        logic [1:0]  op1;
        logic [3:0]  tag1;
        logic [1:0]  exp_ready;
        logic [31:0] res0, res1;
    } vec_t;

    function automatic vec_t mk(logic [1:0] valid, logic hd,
                                logic [31:0] a0, logic [31:0] b0, logic [1:0] op0, logic [3:0] tag0,
                                logic [31:0] a1, logic [31:0] b1, logic [1:0] op1, logic [3:0] tag1,
                                logic [1:0] er, logic [31:0] r0, logic [31:0] r1);
        vec_t v;
        v.valid = valid; v.hold = hd;
        v.a0 = a0; v.b0 = b0; v.op0 = op0; v.tag0 = tag0;
        v.a1 = a1; v.b1 = b1; v.op1 = op1; v.tag1 = tag1;
        v.exp_ready = er; v.res0 = r0; v.res1 = r1;
        return v;
    endfunction

    task automatic apply(vec_t v);
        req_valid     = v.valid;
        hold          = v.hold;
        req_operand1  = {v.a1, v.a0};
        req_operand2  = {v.b1, v.b0};
        req_operation = {v.op1, v.op0};
        req_tag       = {v.tag1, v.tag0};
        @(negedge CLK);
        chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
        if (v.exp_ready[0]) q.push_back('{1'b0, v.tag0, v.res0, cyc});
        if (v.exp_ready[1]) q.push_back('{1'b1, v.tag1, v.res1, cyc});
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(int n);
        repeat (n) apply(mk(2'b00, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    endtask

    vec_t t_mixed[$];
    vec_t t_cont[$];
    vec_t t_credit[$];
    vec_t t_hold[$];

    initial begin
        int n0;
        int n1;
        logic [1:0] v;
        logic [1:0] er;
        logic [3:0] tg;
        logic [3:0] credit_tag;
        logic [1:0] credit_exp [12];

        // Mixed ops: mul on req0 then sub on req1 (leaves last_gnt=1).
        t_mixed.push_back(mk(2'b01, 0, TWO, THREE, 2'b10, 4'd3, 0, 0, 0, 0, 2'b01, SIX, 0));
        t_mixed.push_back(mk(2'b10, 0, 0, 0, 0, 0, FIVE, ONE, 2'b01, 4'd9, 2'b10, 0, FOUR));

        // Contention: req0 adds 1+2, req1 multiplies 2*3, eight ops each.
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 16; k++) begin
            v[0] = (n0 < 8);
            v[1] = (n1 < 8);
            er = (v == 2'b11) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : v;
            t_cont.push_back(mk(v, 0, ONE, TWO, 2'b00, 4'(n0), TWO, THREE, 2'b10, 4'(n1), er, THREE, SIX));
            if (er[0]) n0++;
            if (er[1]) n1++;
        end

        // Credit limit: 4 accepts, 3 stalls, re-issue on each returning credit, then stall.
        credit_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                       2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        credit_tag = 4'd0;
        for (int k = 0; k < 12; k++) begin
            t_credit.push_back(mk(2'b01, 0, ONE, TWO, 2'b00, credit_tag, 0, 0, 0, 0, credit_exp[k], THREE, 0));
            if (credit_exp[k][0]) credit_tag = credit_tag + 4'd1;
        end

        // Hold: three ops in flight, then hold blocks grants while they drain.
        t_hold.push_back(mk(2'b01, 0, ONE, TWO, 2'b00, 4'd1, 0, 0, 0, 0, 2'b01, THREE, 0));
        t_hold.push_back(mk(2'b10, 0, 0, 0, 0, 0, TWO, THREE, 2'b10, 4'd2, 2'b10, 0, SIX));
        t_hold.push_back(mk(2'b01, 0, FIVE, ONE, 2'b01, 4'd3, 0, 0, 0, 0, 2'b01, FOUR, 0));
        for (int k = 0; k < 9; k++)
            t_hold.push_back(mk(2'b11, 1, ONE, TWO, 0, 4'd7, ONE, TWO, 0, 4'd8, 2'b00, 0, 0));

        // Reset state with requests pending.
        RST = 1'b1;
        @(posedge CLK);
        #1;
        repeat (2) begin
            apply(mk(2'b11, 0, ONE, TWO, 2'b10, 4'd1, ONE, TWO, 2'b10, 4'd2, 2'b00, 0, 0));
            chk("rst_fpu_operand1", fpu_operand1, 32'd0);
            chk("rst_fpu_operation", 32'(fpu_operation), 32'd0);
            chk("rst_idle", 32'(idle), 32'd1);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        end
        RST = 1'b0;

        // Single add.
        apply(mk(2'b01, 0, ONE, TWO, 2'b00, 4'd5, 0, 0, 0, 0, 2'b01, THREE, 0));
        chk("add_fpu_operand1", fpu_operand1, ONE);
        chk("add_fpu_operand2", fpu_operand2, TWO);
        chk("add_busy", 32'(idle), 32'd0);
        drain(8);
        chk("add_idle", 32'(idle), 32'd1);

        foreach (t_mixed[i]) apply(t_mixed[i]);
        drain(8);
        chk("mixed_idle", 32'(idle), 32'd1);

        foreach (t_cont[i]) apply(t_cont[i]);
        drain(8);
        chk("cont_idle", 32'(idle), 32'd1);

        foreach (t_credit[i]) apply(t_credit[i]);
        drain(8);
        chk("credit_idle", 32'(idle), 32'd1);

        foreach (t_hold[i]) apply(t_hold[i]);
        drain(2);
        chk("hold_idle", 32'(idle), 32'd1);

        // Reset with three operations in flight: their results must never appear.
        for (int k = 0; k < 3; k++) begin
            tg = 4'(k + 1);
            apply(mk(2'b01, 0, ONE, TWO, 2'b00, tg, 0, 0, 0, 0, 2'b01, THREE, 0));
        end
        chk("inflight_busy", 32'(idle), 32'd0);
        RST = 1'b1;
        q.delete();
        repeat (2) begin
            apply(mk(2'b01, 0, ONE, TWO, 2'b00, 4'd4, 0, 0, 0, 0, 2'b00, 0, 0));
            chk("midrst_idle", 32'(idle), 32'd1);
        end
        RST = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drain(1);
            chk("postrst_idle", 32'(idle), 32'd1);
        end
        chk("pending_responses", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
